// File: rtl/lab2_pkg.sv
// Shared types and character constants for the lab2 adder sequencer.
// State encoding, byte classes and ASCII codes used on the rx/tx byte streams.
package lab2_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_GOT_A    = 3'd1,
      ST_GOT_OP   = 3'd2,
      ST_LAUNCH   = 3'd3,
      ST_WAIT     = 3'd4,
      ST_SEND_RES = 3'd5,
      ST_SEND_NL  = 3'd6
   } state_t;

   typedef enum logic [2:0] {
      CLS_DIGIT = 3'd0,
      CLS_PLUS  = 3'd1,
      CLS_MINUS = 3'd2,
      CLS_CR    = 3'd3,
      CLS_OTHER = 3'd4
   } cls_t;

   localparam logic [7:0] CH_PLUS  = 8'h2B;
   localparam logic [7:0] CH_MINUS = 8'h2D;
   localparam logic [7:0] CH_CR    = 8'h0D;
   localparam logic [7:0] CH_LF    = 8'h0A;
   localparam logic [7:0] CH_ERR   = 8'h21;

   function automatic logic is_busy(input state_t s);
      return (s == ST_LAUNCH) || (s == ST_WAIT) || (s == ST_SEND_RES) || (s == ST_SEND_NL);
   endfunction

endpackage

// File: rtl/lab2_char_class.sv
// Combinational byte classifier: digit (0x30-0x3F), '+', '-', CR or other.
// Zero latency, no flow control.
module lab2_char_class
   import lab2_pkg::*;
(
   input  logic [7:0] i_data,
   output cls_t       o_cls
);

   always_comb begin
      o_cls = CLS_OTHER;
      if (i_data[7:4] == 4'h3)
         o_cls = CLS_DIGIT;
      else if (i_data == CH_PLUS)
         o_cls = CLS_PLUS;
      else if (i_data == CH_MINUS)
         o_cls = CLS_MINUS;
      else if (i_data == CH_CR)
         o_cls = CLS_CR;
   end

endmodule

// File: rtl/lab2_adder_seq_ctrl.sv
// Parses "<A><op><B>" from rx, launches the ASCII adder, returns result (+LF) on tx valid/ready.
// Optional WAIT watchdog enabled by defining ADDER_CTRL_TIMEOUT_EN.
module lab2_adder_seq_ctrl
   import lab2_pkg::*;
#(
   parameter int SEND_NL = 1
`ifdef ADDER_CTRL_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYC = 16
`endif
)(
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   input  logic [7:0] adder_data,
   input  logic       adder_rdy,
   input  logic       tx_ready,
   output logic [7:0] adder_r1,
   output logic [7:0] adder_r2,
   output logic       adder_subtract,
   output logic       adder_start,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   output logic       busy,
   output logic       err,
   output logic       rx_ovf
);

   state_t     r_state;
   state_t     w_state_nxt;
   cls_t       w_cls;
   logic       w_ld_r1;
   logic       w_ld_r2;
   logic       w_ld_sub;
   logic       w_ld_tx;
   logic [7:0] w_tx_nxt;
   logic       w_err;
   logic       w_timeout;
   logic [7:0] r_r1;
   logic [7:0] r_r2;
   logic       r_sub;
   logic [7:0] r_tx_data;
   logic       r_ovf;

   lab2_char_class u_cls (
      .i_data (rx_data),
      .o_cls  (w_cls)
   );

`ifdef ADDER_CTRL_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] r_wait_cnt;

   always_ff @(posedge clk) begin
      if (rst || (r_state != ST_WAIT))
         r_wait_cnt <= '0;
      else if (r_wait_cnt != CNT_LAST)
         r_wait_cnt <= r_wait_cnt + 1'b1;
   end

   // A ready pulse on the last count cycle still wins over the timeout.
   assign w_timeout = (r_state == ST_WAIT) && (r_wait_cnt == CNT_LAST) && !adder_rdy;
`else
   assign w_timeout = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_ld_r1     = 1'b0;
      w_ld_r2     = 1'b0;
      w_ld_sub    = 1'b0;
      w_ld_tx     = 1'b0;
      w_tx_nxt    = r_tx_data;
      w_err       = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (rx_valid) begin
               case (w_cls)
                  CLS_DIGIT: begin
                     w_ld_r1     = 1'b1;
                     w_state_nxt = ST_GOT_A;
                  end
                  CLS_CR: w_state_nxt = ST_IDLE;
                  default: w_err = 1'b1;
               endcase
            end
         end
         ST_GOT_A: begin
            if (rx_valid) begin
               case (w_cls)
                  CLS_PLUS, CLS_MINUS: begin
                     w_ld_sub    = 1'b1;
                     w_state_nxt = ST_GOT_OP;
                  end
                  CLS_CR: w_state_nxt = ST_IDLE;
                  default: w_err = 1'b1;
               endcase
            end
         end
         ST_GOT_OP: begin
            if (rx_valid) begin
               case (w_cls)
                  CLS_DIGIT: begin
                     w_ld_r2     = 1'b1;
                     w_state_nxt = ST_LAUNCH;
                  end
                  CLS_CR: w_state_nxt = ST_IDLE;
                  default: w_err = 1'b1;
               endcase
            end
         end
         ST_LAUNCH: w_state_nxt = ST_WAIT;
         ST_WAIT: begin
            if (adder_rdy) begin
               w_ld_tx     = 1'b1;
               w_tx_nxt    = adder_data;
               w_state_nxt = ST_SEND_RES;
            end else if (w_timeout) begin
               w_err = 1'b1;
            end
         end
         ST_SEND_RES: begin
            if (tx_ready) begin
               if (SEND_NL != 0) begin
                  w_ld_tx     = 1'b1;
                  w_tx_nxt    = CH_LF;
                  w_state_nxt = ST_SEND_NL;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         ST_SEND_NL: begin
            if (tx_ready)
               w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      // Any error (syntax or timeout) reports '!' through the normal result path.
      if (w_err) begin
         w_ld_tx     = 1'b1;
         w_tx_nxt    = CH_ERR;
         w_state_nxt = ST_SEND_RES;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_r1      <= 8'h00;
         r_r2      <= 8'h00;
         r_sub     <= 1'b0;
         r_tx_data <= 8'h00;
         r_ovf     <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_ld_r1)
            r_r1 <= rx_data;
         if (w_ld_r2)
            r_r2 <= rx_data;
         if (w_ld_sub)
            r_sub <= (w_cls == CLS_MINUS);
         if (w_ld_tx)
            r_tx_data <= w_tx_nxt;
         if (rx_valid && is_busy(r_state))
            r_ovf <= 1'b1;
      end
   end

   assign adder_r1       = r_r1;
   assign adder_r2       = r_r2;
   assign adder_subtract = r_sub;
   assign adder_start    = (r_state == ST_LAUNCH);
   assign tx_data        = r_tx_data;
   assign tx_valid       = (r_state == ST_SEND_RES) || (r_state == ST_SEND_NL);
   assign busy           = is_busy(r_state);
   assign err            = w_err;
   assign rx_ovf         = r_ovf;

endmodule

// File: tb/tb_lab2_adder_seq_ctrl.sv
// Directed bench for lab2_adder_seq_ctrl with a 4-cycle adder model.
module tb_lab2_adder_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] adder_data;
   logic       adder_rdy;
   logic       tx_ready;
   logic [7:0] adder_r1, adder_r2, tx_data;
   logic       adder_subtract, adder_start, tx_valid, busy, err, rx_ovf;

   int n_vec = 0;
   int n_err = 0;

   // adder model: ready pulse a few cycles after start, or manual override
   logic       m_en;
   logic [2:0] m_cnt;
   logic       m_rdy;
   logic [7:0] m_data;
   logic       man_rdy;
   logic [7:0] man_data;

   assign adder_rdy  = m_rdy | man_rdy;
   assign adder_data = man_rdy ? man_data : m_data;

   always #5 clk = ~clk;

   lab2_adder_seq_ctrl #(.SEND_NL(1)) dut (
      .clk            (clk),
      .rst            (rst),
      .rx_data        (rx_data),
      .rx_valid       (rx_valid),
      .adder_data     (adder_data),
      .adder_rdy      (adder_rdy),
      .tx_ready       (tx_ready),
      .adder_r1       (adder_r1),
      .adder_r2       (adder_r2),
      .adder_subtract (adder_subtract),
      .adder_start    (adder_start),
      .tx_data        (tx_data),
      .tx_valid       (tx_valid),
      .busy           (busy),
      .err            (err),
      .rx_ovf         (rx_ovf)
   );

   always @(posedge clk) begin
      if (rst) begin
         m_cnt <= 3'd0;
         m_rdy <= 1'b0;
      end else begin
         m_rdy <= 1'b0;
         if (adder_start && m_en) begin
            m_cnt  <= 3'd4;
            m_data <= {4'h3, adder_subtract ? (adder_r1[3:0] - adder_r2[3:0])
                                            : (adder_r1[3:0] + adder_r2[3:0])};
         end else if (m_cnt != 3'd0) begin
            m_cnt <= m_cnt - 3'd1;
            if (m_cnt == 3'd1)
               m_rdy <= 1'b1;
         end
      end
   end

   typedef struct {
      logic [7:0] a;
      logic [7:0] op;
      logic [7:0] b;
      logic       sub;
      logic [7:0] res;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // called at a negedge; returns at the following negedge
   task automatic drive_byte(input logic [7:0] b, output logic e);
      rx_data  = b;
      rx_valid = 1'b1;
      #1 e = err;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic wait_tx(input string nm, input logic [7:0] exp);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 60 && !ok; i++) begin
         if (tx_valid && tx_ready) begin
            chk(nm, {24'h0, tx_data}, {24'h0, exp});
            ok = 1'b1;
         end
         @(negedge clk);
      end
      if (!ok)
         chk({nm, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic check_reset_vals(input string nm);
      chk({nm, "_r1"},  {24'h0, adder_r1}, 32'h0);
      chk({nm, "_r2"},  {24'h0, adder_r2}, 32'h0);
      chk({nm, "_txd"}, {24'h0, tx_data},  32'h0);
      chk({nm, "_flags"}, {25'h0, adder_subtract, adder_start, tx_valid, busy, err, rx_ovf, 1'b0}, 32'h0);
   endtask

   initial begin
      logic e;
      int   cnt;
      vecs[0] = '{8'h33, 8'h2B, 8'h34, 1'b0, 8'h37};
      vecs[1] = '{8'h39, 8'h2D, 8'h35, 1'b1, 8'h34};
      vecs[2] = '{8'h30, 8'h2B, 8'h30, 1'b0, 8'h30};
      vecs[3] = '{8'h3F, 8'h2B, 8'h31, 1'b0, 8'h30};
      vecs[4] = '{8'h32, 8'h2D, 8'h35, 1'b1, 8'h3D};

      rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b1;
      m_en = 1'b1; man_rdy = 1'b0; man_data = 8'h00;
      repeat (3) @(negedge clk);
      check_reset_vals("reset");
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         drive_byte(vecs[i].a, e);
         chk($sformatf("v%0d_busy_idle", i), {31'h0, busy}, 32'd0);
         drive_byte(vecs[i].op, e);
         drive_byte(vecs[i].b, e);
         chk($sformatf("v%0d_start", i), {31'h0, adder_start}, 32'd1);
         chk($sformatf("v%0d_ops", i), {15'h0, adder_subtract, adder_r1, adder_r2},
             {15'h0, vecs[i].sub, vecs[i].a, vecs[i].b});
         @(negedge clk);
         chk($sformatf("v%0d_start_1cyc", i), {31'h0, adder_start}, 32'd0);
         wait_tx($sformatf("v%0d_res", i), vecs[i].res);
         wait_tx($sformatf("v%0d_lf", i), 8'h0A);
         chk($sformatf("v%0d_busy_done", i), {30'h0, busy, tx_valid}, 32'd0);
      end

      // syntax error on the operator byte
      drive_byte(8'h33, e);
      chk("err_quiet_digit", {31'h0, e}, 32'd0);
      drive_byte(8'h78, e);
      chk("err_pulse", {31'h0, e}, 32'd1);
      chk("err_1cyc", {31'h0, err}, 32'd0);
      chk("err_r1_kept", {24'h0, adder_r1}, 32'h33);
      wait_tx("err_bang", 8'h21);
      wait_tx("err_lf", 8'h0A);

      // CR abandons a partial expression silently
      drive_byte(8'h33, e);
      drive_byte(8'h0D, e);
      chk("cr_no_err", {31'h0, e}, 32'd0);
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
         if (tx_valid || busy || err) cnt++;
         @(negedge clk);
      end
      chk("cr_silent", cnt, 32'd0);

      // downstream stall during SEND_RES
      tx_ready = 1'b0;
      drive_byte(8'h33, e);
      drive_byte(8'h2B, e);
      drive_byte(8'h34, e);
      cnt = 0;
      while (!tx_valid && cnt < 30) begin
         @(negedge clk);
         cnt++;
      end
      chk("stall_reach", {31'h0, tx_valid}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("stall_hold%0d", i), {23'h0, tx_valid, tx_data}, {23'h0, 1'b1, 8'h37});
         @(negedge clk);
      end
      tx_ready = 1'b1;
      wait_tx("stall_res", 8'h37);
      wait_tx("stall_lf", 8'h0A);

      // rx byte during WAIT is dropped and flagged
      drive_byte(8'h31, e);
      drive_byte(8'h2B, e);
      drive_byte(8'h32, e);
      @(negedge clk);
      drive_byte(8'h35, e);
      chk("ovf_set", {31'h0, rx_ovf}, 32'd1);
      wait_tx("ovf_res", 8'h33);
      wait_tx("ovf_lf", 8'h0A);
      chk("ovf_sticky", {31'h0, rx_ovf}, 32'd1);
      chk("ovf_r1_kept", {24'h0, adder_r1}, 32'h31);

      rst = 1'b1;
      repeat (2) @(negedge clk);
      check_reset_vals("rst2");
      rst = 1'b0;
      @(negedge clk);

      // reset while waiting discards the result
      drive_byte(8'h31, e);
      drive_byte(8'h2B, e);
      drive_byte(8'h31, e);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      cnt = 0;
      for (int i = 0; i < 15; i++) begin
         if (tx_valid || busy) cnt++;
         @(negedge clk);
      end
      chk("rst_wait_discard", cnt, 32'd0);

`ifdef ADDER_CTRL_TIMEOUT_EN
      m_en = 1'b0;
      drive_byte(8'h31, e);
      drive_byte(8'h2B, e);
      drive_byte(8'h31, e);
      cnt = 0;
      for (int i = 1; i <= 40 && cnt == 0; i++) begin
         @(negedge clk);
         #1 if (err) cnt = i;
      end
      chk("to_cycle", cnt, 32'd16);
      @(negedge clk);
      wait_tx("to_bang", 8'h21);
      wait_tx("to_lf", 8'h0A);

      drive_byte(8'h31, e);
      drive_byte(8'h2B, e);
      drive_byte(8'h31, e);
      cnt = 0;
      for (int i = 1; i <= 15; i++) begin
         @(negedge clk);
         #1 if (err) cnt++;
      end
      @(negedge clk);
      man_data = 8'h55;
      man_rdy  = 1'b1;
      #1 if (err) cnt++;
      chk("to_rdy_wins_noerr", cnt, 32'd0);
      @(negedge clk);
      man_rdy = 1'b0;
      wait_tx("to_rdy_res", 8'h55);
      wait_tx("to_rdy_lf", 8'h0A);
      m_en = 1'b1;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
